// File: rtl/vdec_pkg.sv
// ----------------------------------------------------------------------------
// vdec_pkg
// Shared definitions for the Viterbi decoder traceback blocks.
//   - default geometry: state width, pointer word width, block and tail limits
//   - clog2 helper used to size addresses and counters
//   - traceback FSM state type
// ----------------------------------------------------------------------------
package vdec_pkg;

    localparam int unsigned ST_W_D     = 8;
    localparam int unsigned PT_W_D     = 32;
    localparam int unsigned MAX_BLK_D  = 29;
    localparam int unsigned MAX_TAIL_D = 8;

    // Smallest r such that 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    // Pointer RAM words per trellis stage.
    localparam int unsigned WPS_D = (32'd1 << ST_W_D) / PT_W_D;
    localparam int unsigned AW_D  = clog2((MAX_BLK_D + MAX_TAIL_D) * WPS_D);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } tb_state_e;

endpackage

// File: rtl/vdec_tb_bwd_if.sv
// ----------------------------------------------------------------------------
// vdec_tb_bwd_if
// Pointer (survivor-decision) RAM read port used by the traceback.
//   pt_rd    read enable (traceback -> RAM)
//   pt_addr  word address (traceback -> RAM)
//   pt_dout  read data, valid one cycle after pt_rd (RAM -> traceback)
// master: traceback side, slave: RAM side.
// ----------------------------------------------------------------------------
interface vdec_tb_bwd_if
    import vdec_pkg::*;
#(
    parameter int unsigned AW   = AW_D,
    parameter int unsigned PT_W = PT_W_D
);
    logic            pt_rd;
    logic [AW-1:0]   pt_addr;
    logic [PT_W-1:0] pt_dout;

    modport master (output pt_rd, output pt_addr, input  pt_dout);
    modport slave  (input  pt_rd, input  pt_addr, output pt_dout);
endinterface

// File: rtl/vdec_tb_sel.sv
// ----------------------------------------------------------------------------
// vdec_tb_sel
// Combinational traceback step: picks the survivor decision for the current
// state out of one pointer RAM word and forms the predecessor state.
//   cur_state  current trellis state
//   pt_dout    pointer RAM word holding this state's decision bit
//   b          decision bit (also the decoded bit for this stage)
//   pre_state  predecessor state = {b, cur_state[ST_W-1:1]}
// ----------------------------------------------------------------------------
module vdec_tb_sel
    import vdec_pkg::*;
#(
    parameter int unsigned ST_W = ST_W_D,
    parameter int unsigned PT_W = PT_W_D
) (
    input  logic [ST_W-1:0] cur_state,
    input  logic [PT_W-1:0] pt_dout,
    output logic            b,
    output logic [ST_W-1:0] pre_state
);
    localparam int unsigned LPT = clog2(PT_W);

    assign b         = pt_dout[cur_state[LPT-1:0]];
    assign pre_state = {b, cur_state[ST_W-1:1]};
endmodule

// File: rtl/vdec_tb_bwd.sv
// ----------------------------------------------------------------------------
// vdec_tb_bwd
// Viterbi backward traceback. Walks the pointer RAM from stage N-1 down to
// stage 0 (N = blk_size + tail_len), one stage per cycle, and shifts the
// decisions of stages below blk_size into dec_bits (stage k -> bit k).
//   clk, rst    clock, asynchronous active-high reset
//   start       one-cycle pulse, latches config and starts a traceback
//   blk_size    information bits (1..MAX_BLK)
//   tail_len    tail stages discarded first (0..MAX_TAIL)
//   init_state  traceback start state
//   abort       cancel a running traceback (done+err follow)
//   busy        traceback in progress
//   done, err   completion pulse; err=1 for illegal config or abort
//   dec_bits    decoded bits, held until the next legal start
//   pt          pointer RAM read port (master)
// ----------------------------------------------------------------------------
module vdec_tb_bwd
    import vdec_pkg::*;
#(
    parameter int unsigned ST_W     = ST_W_D,
    parameter int unsigned PT_W     = PT_W_D,
    parameter int unsigned MAX_BLK  = MAX_BLK_D,
    parameter int unsigned MAX_TAIL = MAX_TAIL_D,
    localparam int unsigned BW      = clog2(MAX_BLK + 1),
    localparam int unsigned TW      = clog2(MAX_TAIL + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BW-1:0]      blk_size,
    input  logic [TW-1:0]      tail_len,
    input  logic [ST_W-1:0]    init_state,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [MAX_BLK-1:0] dec_bits,
    vdec_tb_bwd_if.master      pt
);
    localparam int unsigned WPS = (32'd1 << ST_W) / PT_W;
    localparam int unsigned LPT = clog2(PT_W);
    localparam int unsigned AW  = clog2((MAX_BLK + MAX_TAIL) * WPS);
    localparam int unsigned SW  = clog2(MAX_BLK + MAX_TAIL);

    tb_state_e       state_q, state_d;
    logic [ST_W-1:0] cur_state;
    logic [SW-1:0]   stage;      // stage of the next decision to arrive
    logic [BW-1:0]   blk_r;
    logic            rd_d1;      // pt_dout carries valid data this cycle
    logic            aborted;

    logic            b;
    logic [ST_W-1:0] pre_state;
    logic            cfg_ok, go, kill, last_issue;
    logic [SW-1:0]   issue_stage, n_m1;
    logic [ST_W-1:0] word_state;

    vdec_tb_sel #(.ST_W(ST_W), .PT_W(PT_W)) u_sel (
        .cur_state (cur_state),
        .pt_dout   (pt.pt_dout),
        .b         (b),
        .pre_state (pre_state)
    );

    assign cfg_ok = (blk_size != '0) && (int'(blk_size) <= MAX_BLK) &&
                    (int'(tail_len) <= MAX_TAIL);
    assign go     = (state_q == IDLE) && start && !abort;
    assign kill   = abort && ((state_q == RUN) || (state_q == DRAIN));
    assign n_m1   = SW'(blk_size) + SW'(tail_len) - SW'(1);

    // The first read of a run uses the loaded start state; every later read
    // is addressed from the predecessor state decoded in the same cycle, so
    // reads go out back to back with no bubble.
    assign issue_stage = rd_d1 ? (stage - SW'(1)) : stage;
    assign word_state  = rd_d1 ? pre_state : cur_state;
    assign last_issue  = (issue_stage == '0);

    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign pt.pt_rd = (state_q == RUN);

    always_comb begin
        pt.pt_addr = '0;
        if (state_q == RUN)
            pt.pt_addr = AW'(issue_stage) * AW'(WPS) + AW'(word_state >> LPT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go && cfg_ok) state_d = RUN;
            RUN:     if (abort || last_issue) state_d = DRAIN;
            DRAIN:   if (!abort) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= '0;
            stage     <= '0;
            blk_r     <= '0;
            rd_d1     <= 1'b0;
            aborted   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            dec_bits  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (go) begin
                if (cfg_ok) begin
                    cur_state <= init_state;
                    stage     <= n_m1;
                    blk_r     <= blk_size;
                    rd_d1     <= 1'b0;
                    aborted   <= 1'b0;
                    dec_bits  <= '0;
                end else begin
                    done <= 1'b1;
                    err  <= 1'b1;
                end
            end else if (kill) begin
                // Drop the in-flight word; DRAIN then only signals completion.
                rd_d1   <= 1'b0;
                aborted <= 1'b1;
            end else begin
                rd_d1 <= (state_q == RUN);
                if (rd_d1) begin
                    cur_state <= pre_state;
                    if (stage != '0) stage <= stage - SW'(1);
                    // Tail stages sit at the top (stage >= blk_size) and are
                    // the first to arrive, so they are simply not shifted in.
                    if (stage < SW'(blk_r))
                        dec_bits <= {dec_bits[MAX_BLK-2:0], b};
                end
                if (state_q == DRAIN) begin
                    done <= 1'b1;
                    err  <= aborted;
                end
            end
        end
    end
endmodule

// File: tb/tb_vdec_tb_bwd.sv
module tb_vdec_tb_bwd;
    import vdec_pkg::*;

    localparam int unsigned ST_W     = ST_W_D;
    localparam int unsigned PT_W     = PT_W_D;
    localparam int unsigned MAX_BLK  = MAX_BLK_D;
    localparam int unsigned MAX_TAIL = MAX_TAIL_D;
    localparam int unsigned WPS      = (32'd1 << ST_W) / PT_W;
    localparam int unsigned AW       = clog2((MAX_BLK + MAX_TAIL) * WPS);
    localparam int unsigned BW       = clog2(MAX_BLK + 1);
    localparam int unsigned TW       = clog2(MAX_TAIL + 1);
    localparam int unsigned MEM_N    = 32'd1 << AW;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [BW-1:0]      blk_size;
    logic [TW-1:0]      tail_len;
    logic [ST_W-1:0]    init_state;
    logic               abort;
    logic               busy, done, err;
    logic [MAX_BLK-1:0] dec_bits;

    vdec_tb_bwd_if #(.AW(AW), .PT_W(PT_W)) pt ();

    vdec_tb_bwd #(
        .ST_W(ST_W), .PT_W(PT_W), .MAX_BLK(MAX_BLK), .MAX_TAIL(MAX_TAIL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .blk_size(blk_size),
        .tail_len(tail_len), .init_state(init_state), .abort(abort),
        .busy(busy), .done(done), .err(err), .dec_bits(dec_bits), .pt(pt)
    );

    always #5 clk = ~clk;

    // Pointer RAM: registered read, data one cycle after pt_rd.
    logic [PT_W-1:0] mem [0:MEM_N-1];
    always @(posedge clk) if (pt.pt_rd) pt.pt_dout <= mem[pt.pt_addr];

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference traceback: addresses and decoded bits straight from the
    // trellis rules, walking stage by stage over the RAM contents.
    int                 m_addr[$];
    logic [MAX_BLK-1:0] m_dec;
    int                 got_addr[$];
    logic [MAX_BLK-1:0] exp_dec = '0;
    bit                 dec_known = 1'b1;

    task automatic model(input int blk, input int tail, input int init);
        int s, a;
        logic [PT_W-1:0] w;
        logic bt;
        m_addr.delete();
        m_dec = '0;
        s = init;
        for (int st = blk + tail - 1; st >= 0; st--) begin
            a = st * WPS + s / PT_W;
            m_addr.push_back(a);
            w = mem[a];
            bt = w[s % PT_W];
            if (st < blk) m_dec[st] = bt;
            s = (s >> 1) | (int'(bt) << (ST_W - 1));
        end
    endtask

    // Rewrites the RAM so the path from init follows pat[stage].
    task automatic force_path(input int blk, input int tail, input int init, input logic [63:0] pat);
        int s, a;
        logic [PT_W-1:0] w;
        s = init;
        for (int st = blk + tail - 1; st >= 0; st--) begin
            a = st * WPS + s / PT_W;
            w = mem[a];
            w[s % PT_W] = pat[st];
            mem[a] = w;
            s = (s >> 1) | (int'(pat[st]) << (ST_W - 1));
        end
    endtask

    task automatic fill_mem(input int mode);
        for (int i = 0; i < MEM_N; i++)
            mem[i] = (mode == 0) ? '0 : (mode == 1) ? '1 : PT_W'($urandom);
    endtask

    task automatic run_tx(input int blk, input int tail, input int init,
                          input int abort_cyc, input int extra_cyc);
        bit legal, seen_done;
        int n, cyc, nrd, exp_reads, exp_done;
        legal = (blk >= 1) && (blk <= MAX_BLK) && (tail <= MAX_TAIL);
        n = blk + tail;
        m_addr.delete();
        if (legal) model(blk, tail, init);
        exp_reads = !legal ? 0 : (abort_cyc > 0) ? abort_cyc : n;
        exp_done  = !legal ? 1 : (abort_cyc > 0) ? abort_cyc + 2 : n + 2;
        got_addr.delete();

        @(negedge clk);
        start = 1'b1; abort = 1'b0;
        blk_size = BW'(blk); tail_len = TW'(tail); init_state = ST_W'(init);
        @(negedge clk);
        start = 1'b0;
        blk_size = BW'($urandom); tail_len = TW'($urandom); init_state = ST_W'($urandom);
        cyc = 1; nrd = 0; seen_done = 1'b0;
        check_eq("busy_c1", busy, legal);
        while (cyc < 200) begin
            if (pt.pt_rd) begin
                got_addr.push_back(int'(pt.pt_addr));
                if (nrd < m_addr.size()) check_eq("pt_addr", pt.pt_addr, m_addr[nrd]);
                nrd++;
            end
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            start = (cyc == extra_cyc);
            abort = (cyc == abort_cyc);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; abort = 1'b0;
        check_eq("done_seen", seen_done, 1);
        check_eq("done_cycle", cyc, exp_done);
        check_eq("reads", nrd, exp_reads);
        check_eq("err", err, (!legal || abort_cyc > 0));
        check_eq("busy_at_done", busy, 0);
        if (legal && abort_cyc == 0) begin
            check_eq("dec_bits", dec_bits, m_dec);
            exp_dec = m_dec;
            dec_known = 1'b1;
        end else if (!legal && dec_known) begin
            check_eq("dec_hold", dec_bits, exp_dec);
        end
        if (legal && abort_cyc > 0) dec_known = 1'b0;
        @(negedge clk);
        check_eq("done_pulse", done, 0);
        check_eq("err_clear", err, 0);
    endtask

    initial begin
        int blk, tail, ab;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        blk_size = '0; tail_len = '0; init_state = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_pt_rd", pt.pt_rd, 0);
        check_eq("rst_pt_addr", pt.pt_addr, 0);
        check_eq("rst_dec", dec_bits, 0);
        rst = 1'b0;

        // All-zero decisions from state 0.
        fill_mem(0);
        run_tx(29, 8, 0, 0, 0);
        check_eq("zero_first_addr", (got_addr.size() > 0) ? got_addr[0] : -1, 288);
        check_eq("zero_dec", dec_bits, 0);

        // All-one decisions: address walk climbs through the word index.
        fill_mem(1);
        run_tx(29, 8, 0, 0, 0);
        check_eq("ones_addr1", (got_addr.size() > 3) ? got_addr[1] : -1, 284);
        check_eq("ones_addr2", (got_addr.size() > 3) ? got_addr[2] : -1, 278);
        check_eq("ones_addr3", (got_addr.size() > 3) ? got_addr[3] : -1, 271);
        check_eq("ones_dec", dec_bits, 29'h1FFF_FFFF);

        // Short block, no tail, nonzero start state.
        fill_mem(2);
        force_path(5, 0, 8'hA5, 64'b10110);
        run_tx(5, 0, 8'hA5, 0, 0);
        check_eq("pat_first_addr", (got_addr.size() > 0) ? got_addr[0] : -1, 37);
        check_eq("pat_dec", dec_bits, 29'b10110);

        // Illegal configurations.
        run_tx(30, 8, 0, 0, 0);
        run_tx(0, 3, 0, 0, 0);
        run_tx(10, 9, 0, 0, 0);

        // Abort at cycle 10 with an ignored restart at cycle 5.
        fill_mem(2);
        run_tx(29, 8, int'($urandom_range(255)), 10, 5);

        // Asynchronous reset in the middle of a run.
        fill_mem(2);
        @(negedge clk);
        start = 1'b1; blk_size = BW'(29); tail_len = TW'(8); init_state = ST_W'($urandom);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_err", err, 0);
        check_eq("arst_pt_rd", pt.pt_rd, 0);
        check_eq("arst_pt_addr", pt.pt_addr, 0);
        check_eq("arst_dec", dec_bits, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_dec = '0; dec_known = 1'b1;
        run_tx(29, 8, int'($urandom_range(255)), 0, 0);

        // Randomized runs, some with abort and stray starts.
        for (int r = 0; r < 25; r++) begin
            fill_mem(2);
            blk  = int'($urandom_range(MAX_BLK, 1));
            tail = int'($urandom_range(MAX_TAIL, 0));
            ab   = ($urandom_range(4) == 0) ? int'($urandom_range(blk + tail, 1)) : 0;
            run_tx(blk, tail, int'($urandom_range(255)), ab, int'($urandom_range(blk + tail, 1)));
        end
        run_tx(0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
